// File: rtl/dram_req_sched.sv
// Read/write request scheduler feeding a single DRAM command port.
// Batches writes into watermark-bounded drain bursts with a turnaround bubble on each mode change.
module dram_req_sched #(
  parameter int RQ_W      = 32,
  parameter int WQ_W      = 96,
  parameter int MIN_BURST = 4,
  parameter int TURN_CYC  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rq_empty_i,
  input  logic [RQ_W-1:0] rq_data_i,
  output logic            rq_pop_o,
  input  logic            wq_empty_i,
  input  logic            wq_a_full_i,
  input  logic            wq_a_empty_i,
  input  logic [WQ_W-1:0] wq_data_i,
  output logic            wq_pop_o,
  output logic            cmd_valid_o,
  input  logic            cmd_ready_i,
  output logic            cmd_we_o,
  output logic [WQ_W-1:0] cmd_data_o,
  output logic            mode_o
);

  localparam int BW = $clog2(MIN_BURST + 1);
  localparam int TW = $clog2(TURN_CYC + 1);

  typedef enum logic [1:0] {
    RD     = 2'd0,
    TURN_W = 2'd1,
    WR     = 2'd2,
    TURN_R = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   burstCnt_q, burstCnt_d;
  logic [TW-1:0]   turnCnt_q, turnCnt_d;
  logic            cmdValid_q, cmdValid_d;
  logic            cmdWe_q, cmdWe_d;
  logic [WQ_W-1:0] cmdData_q, cmdData_d;
  logic            mode_q, mode_d;

  logic loadOk;
  logic burstDone;
  logic swRd;
  logic swWr;
  logic inTurn;
  logic enterTurn;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RD;
      burstCnt_q <= '0;
      turnCnt_q  <= '0;
      cmdValid_q <= 1'b0;
      cmdWe_q    <= 1'b0;
      cmdData_q  <= '0;
      mode_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      burstCnt_q <= burstCnt_d;
      turnCnt_q  <= turnCnt_d;
      cmdValid_q <= cmdValid_d;
      cmdWe_q    <= cmdWe_d;
      cmdData_q  <= cmdData_d;
      mode_q     <= mode_d;
    end
  end

  // Switch requests block the pop in the same cycle, so a switch and a pop never coincide.
  always_comb begin
    loadOk    = !cmdValid_q || cmd_ready_i;
    burstDone = (burstCnt_q == BW'(MIN_BURST));
    swRd      = !(rq_empty_i && wq_empty_i) &&
                ((wq_a_full_i && burstDone) || (rq_empty_i && !wq_empty_i));
    swWr      = !rq_empty_i && ((wq_a_empty_i && burstDone) || wq_empty_i);
    rq_pop_o  = rst_n && (state_q == RD) && loadOk && !rq_empty_i && !swRd;
    wq_pop_o  = rst_n && (state_q == WR) && loadOk && !wq_empty_i && !swWr;
    cmd_valid_o = cmdValid_q;
    cmd_we_o    = cmdWe_q;
    cmd_data_o  = cmdData_q;
    mode_o      = mode_q;
  end

  always_comb begin
    state_d    = state_q;
    burstCnt_d = burstCnt_q;
    turnCnt_d  = turnCnt_q;
    cmdValid_d = cmdValid_q;
    cmdWe_d    = cmdWe_q;
    cmdData_d  = cmdData_q;
    inTurn     = (state_q == TURN_W) || (state_q == TURN_R);

    case (state_q)
      RD:      if (swRd) state_d = TURN_W;
      WR:      if (swWr) state_d = TURN_R;
      TURN_W:  if (turnCnt_q == TW'(TURN_CYC - 1)) state_d = WR;
      TURN_R:  if (turnCnt_q == TW'(TURN_CYC - 1)) state_d = RD;
      default: state_d = RD;
    endcase

    enterTurn = !inTurn && ((state_d == TURN_W) || (state_d == TURN_R));

    if (enterTurn) begin
      burstCnt_d = '0;
      turnCnt_d  = '0;
    end else begin
      if (inTurn) turnCnt_d = turnCnt_q + TW'(1);
      if ((rq_pop_o || wq_pop_o) && !burstDone) burstCnt_d = burstCnt_q + BW'(1);
    end

    if (rq_pop_o) begin
      cmdValid_d = 1'b1;
      cmdWe_d    = 1'b0;
      cmdData_d  = WQ_W'(rq_data_i);
    end else if (wq_pop_o) begin
      cmdValid_d = 1'b1;
      cmdWe_d    = 1'b1;
      cmdData_d  = wq_data_i;
    end else if (loadOk) begin
      cmdValid_d = 1'b0;
    end

    mode_d = (state_d == WR) || (state_d == TURN_W);
  end

endmodule

// File: tb/tb_dram_req_sched.sv
// Bench for dram_req_sched: FIFO queues plus a mode/bubble reference model checked every cycle,
// followed by directed scenarios and a randomized run with occasional resets.
module tb_dram_req_sched;

  localparam int RQ_W      = 32;
  localparam int WQ_W      = 96;
  localparam int MIN_BURST = 4;
  localparam int TURN_CYC  = 2;
  localparam int AF_TH     = 6;
  localparam int AE_TH     = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            rq_empty_i;
  logic [RQ_W-1:0] rq_data_i;
  logic            rq_pop_o;
  logic            wq_empty_i;
  logic            wq_a_full_i;
  logic            wq_a_empty_i;
  logic [WQ_W-1:0] wq_data_i;
  logic            wq_pop_o;
  logic            cmd_valid_o;
  logic            cmd_ready_i;
  logic            cmd_we_o;
  logic [WQ_W-1:0] cmd_data_o;
  logic            mode_o;

  dram_req_sched #(
    .RQ_W(RQ_W), .WQ_W(WQ_W), .MIN_BURST(MIN_BURST), .TURN_CYC(TURN_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rq_empty_i(rq_empty_i), .rq_data_i(rq_data_i), .rq_pop_o(rq_pop_o),
    .wq_empty_i(wq_empty_i), .wq_a_full_i(wq_a_full_i), .wq_a_empty_i(wq_a_empty_i),
    .wq_data_i(wq_data_i), .wq_pop_o(wq_pop_o),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i), .cmd_we_o(cmd_we_o),
    .cmd_data_o(cmd_data_o), .mode_o(mode_o)
  );

  always #5 clk = ~clk;

  logic [RQ_W-1:0] rqQ[$];
  logic [WQ_W-1:0] wqQ[$];

  // Reference model: target mode, bubble cycles remaining, pops in current mode, command register.
  bit              mWrite = 0;
  int              mTurnLeft = 0;
  int              mBurst = 0;
  bit              mValid = 0;
  bit              mWe = 0;
  logic [WQ_W-1:0] mData = '0;

  int checks = 0;
  int failures = 0;
  bit checkEn = 0;

  bit              obsRq, obsWq, obsValid, obsWe, obsMode;
  logic [WQ_W-1:0] obsData;
  bit              trRq[$], trWq[$], trMode[$], trValid[$], trWe[$];
  logic [WQ_W-1:0] trData[$];

  task automatic checkOutput(input string tag, input logic [WQ_W-1:0] observed,
                             input logic [WQ_W-1:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit rstnV, input bit readyV);
    rst_n        = rstnV;
    cmd_ready_i  = readyV;
    rq_empty_i   = (rqQ.size() == 0);
    rq_data_i    = (rqQ.size() != 0) ? rqQ[0] : $urandom;
    wq_empty_i   = (wqQ.size() == 0);
    wq_data_i    = (wqQ.size() != 0) ? wqQ[0] : {$urandom, $urandom, $urandom};
    wq_a_full_i  = (wqQ.size() >= AF_TH);
    wq_a_empty_i = (wqQ.size() <= AE_TH);
  endtask

  task automatic runCycle(input bit rstnV, input bit readyV);
    bit              loadOk, leave, expRq, expWq;
    int              rqN, wqN;
    logic [RQ_W-1:0] headR;
    applyStimulus(rstnV, readyV);
    #1;
    rqN    = rqQ.size();
    wqN    = wqQ.size();
    loadOk = !mValid || readyV;
    leave  = 0;
    if (mTurnLeft == 0) begin
      if (!mWrite) leave = (wqN > 0) && ((rqN == 0) || (wqN >= AF_TH && mBurst == MIN_BURST));
      else         leave = (rqN > 0) && ((wqN == 0) || (wqN <= AE_TH && mBurst == MIN_BURST));
    end
    expRq = rstnV && (mTurnLeft == 0) && !mWrite && !leave && loadOk && (rqN > 0);
    expWq = rstnV && (mTurnLeft == 0) &&  mWrite && !leave && loadOk && (wqN > 0);

    obsRq = rq_pop_o; obsWq = wq_pop_o; obsValid = cmd_valid_o;
    obsWe = cmd_we_o; obsData = cmd_data_o; obsMode = mode_o;
    trRq.push_back(obsRq); trWq.push_back(obsWq); trMode.push_back(obsMode);
    trValid.push_back(obsValid); trWe.push_back(obsWe); trData.push_back(obsData);

    if (checkEn) begin
      checkOutput("rq_pop", {95'd0, obsRq}, {95'd0, expRq});
      checkOutput("wq_pop", {95'd0, obsWq}, {95'd0, expWq});
      checkOutput("cmd_valid", {95'd0, obsValid}, {95'd0, mValid});
      checkOutput("mode", {95'd0, obsMode}, {95'd0, mWrite});
      if (mValid) begin
        checkOutput("cmd_we", {95'd0, obsWe}, {95'd0, mWe});
        checkOutput("cmd_data", obsData, mData);
      end
    end

    if (!rstnV) begin
      mWrite = 0; mTurnLeft = 0; mBurst = 0; mValid = 0; mWe = 0; mData = '0;
    end else begin
      if (expRq) begin
        headR = rqQ.pop_front();
        mValid = 1; mWe = 0; mData = '0; mData[RQ_W-1:0] = headR;
      end else if (expWq) begin
        mValid = 1; mWe = 1; mData = wqQ.pop_front();
      end else if (loadOk) begin
        mValid = 0;
      end
      if (mTurnLeft > 0) mTurnLeft--;
      else if (leave) begin mWrite = !mWrite; mTurnLeft = TURN_CYC; mBurst = 0; end
      else if ((expRq || expWq) && mBurst < MIN_BURST) mBurst++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic flush();
    rqQ.delete(); wqQ.delete();
    runCycle(0, 1);
    trRq.delete(); trWq.delete(); trMode.delete();
    trValid.delete(); trWe.delete(); trData.delete();
  endtask

  initial begin
    logic [WQ_W-1:0] expRd[3];
    int n, firstW, firstR2, readsBefore, bubble1, writesBurst, bubble2, idxPop, idxCmd;

    // Reset hold with both queues non-empty, then release.
    rqQ.push_back(32'hA1); rqQ.push_back(32'hA2); wqQ.push_back(96'hB1);
    runCycle(0, 1);
    checkEn = 1;
    for (int i = 0; i < 2; i++) begin
      runCycle(0, 1);
      checkOutput("rst_valid", {95'd0, obsValid}, 96'd0);
      checkOutput("rst_pops", {94'd0, obsRq, obsWq}, 96'd0);
      checkOutput("rst_mode", {95'd0, obsMode}, 96'd0);
      checkOutput("rst_data", obsData, 96'd0);
    end
    runCycle(1, 1);
    checkOutput("rel_rq_pop", {95'd0, obsRq}, 96'd1);
    for (int i = 0; i < 12; i++) runCycle(1, 1);

    // Reads only.
    flush();
    rqQ.push_back(32'h10); rqQ.push_back(32'h20); rqQ.push_back(32'h30);
    for (int i = 0; i < 6; i++) runCycle(1, 1);
    expRd[0] = 96'h10; expRd[1] = 96'h20; expRd[2] = 96'h30;
    n = 0;
    foreach (trValid[i]) if (trValid[i]) begin
      if (n < 3) checkOutput($sformatf("rd_data%0d", n), trData[i], expRd[n]);
      checkOutput("rd_we", {95'd0, trWe[i]}, 96'd0);
      n++;
    end
    checkOutput("rd_cmd_count", 96'(n), 96'd3);
    n = 0;
    foreach (trRq[i]) if (trRq[i]) n++;
    checkOutput("rd_pop_count", 96'(n), 96'd3);

    // Backpressure.
    flush();
    rqQ.push_back(32'h10); rqQ.push_back(32'h20); rqQ.push_back(32'h30); rqQ.push_back(32'h40);
    runCycle(1, 1);
    runCycle(1, 1);
    for (int i = 0; i < 4; i++) begin
      runCycle(1, 0);
      checkOutput("bp_data", obsData, 96'h20);
      checkOutput("bp_valid", {95'd0, obsValid}, 96'd1);
      checkOutput("bp_we", {95'd0, obsWe}, 96'd0);
      checkOutput("bp_nopop", {95'd0, obsRq}, 96'd0);
    end
    runCycle(1, 1);
    checkOutput("bp_resume_pop", {95'd0, obsRq}, 96'd1);
    for (int i = 0; i < 4; i++) runCycle(1, 1);

    // Watermark drain.
    flush();
    for (int i = 0; i < 10; i++) rqQ.push_back($urandom);
    for (int i = 0; i < 8; i++) wqQ.push_back({$urandom, $urandom, $urandom});
    for (int i = 0; i < 30; i++) runCycle(1, 1);
    firstW = -1; firstR2 = -1;
    foreach (trWq[i]) if (trWq[i] && firstW < 0) firstW = i;
    if (firstW >= 0) foreach (trRq[i]) if (i > firstW && trRq[i] && firstR2 < 0) firstR2 = i;
    readsBefore = 0; bubble1 = 0; writesBurst = 0; bubble2 = 0;
    foreach (trRq[i]) begin
      if (firstW >= 0 && i < firstW && trRq[i]) readsBefore++;
      if (firstW >= 0 && i < firstW && trMode[i]) bubble1++;
      if (firstR2 >= 0 && i >= firstW && i < firstR2 && trWq[i]) writesBurst++;
      if (firstR2 >= 0 && i > firstW && i < firstR2 && !trMode[i]) bubble2++;
    end
    checkOutput("drain_reads", 96'(readsBefore), 96'd4);
    checkOutput("drain_bubble_w", 96'(bubble1), 96'(TURN_CYC));
    checkOutput("drain_writes", 96'(writesBurst), 96'd6);
    checkOutput("drain_bubble_r", 96'(bubble2), 96'(TURN_CYC));

    // Empty-read switch.
    flush();
    wqQ.push_back(96'hCAFE);
    for (int i = 0; i < 8; i++) runCycle(1, 1);
    idxPop = -1; idxCmd = -1;
    foreach (trWq[i]) if (trWq[i] && idxPop < 0) idxPop = i;
    foreach (trValid[i]) if (trValid[i] && trWe[i] && idxCmd < 0) idxCmd = i;
    checkOutput("ers_turn_mode", {95'd0, trMode[1]}, 96'd1);
    checkOutput("ers_pop_cycle", 96'(idxPop), 96'd3);
    checkOutput("ers_cmd_cycle", 96'(idxCmd), 96'd4);
    checkOutput("ers_cmd_data", trData[4], 96'hCAFE);
    checkOutput("ers_stay_wr", {95'd0, trMode[7]}, 96'd1);

    // Reset mid-drain with a pending write.
    flush();
    for (int i = 0; i < 5; i++) wqQ.push_back({$urandom, $urandom, $urandom});
    for (int i = 0; i < 4; i++) runCycle(1, 1);
    runCycle(1, 0);
    checkOutput("rmd_pending", {94'd0, obsValid, obsWe}, 96'd3);
    runCycle(0, 0);
    checkOutput("rmd_rst_nopop", {94'd0, obsRq, obsWq}, 96'd0);
    rqQ.push_back(32'h55);
    runCycle(1, 0);
    checkOutput("rmd_valid_drop", {95'd0, obsValid}, 96'd0);
    checkOutput("rmd_mode_rd", {95'd0, obsMode}, 96'd0);
    checkOutput("rmd_rd_pop", {95'd0, obsRq}, 96'd1);

    // Randomized traffic with occasional resets.
    flush();
    for (int i = 0; i < 3000; i++) begin
      if (rqQ.size() < 12 && $urandom_range(0, 9) < 4) rqQ.push_back($urandom);
      if (wqQ.size() < 12 && $urandom_range(0, 9) < 4) wqQ.push_back({$urandom, $urandom, $urandom});
      runCycle(($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1, ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
